// File: rtl/intr_nest_unit.sv
// Vectored, fixed-priority nested interrupt unit with a hardware return stack.
// Nesting beyond one level is enabled by defining INTR_NEST_EN; otherwise one level.
module intr_nest_unit #(
  parameter int ADDR_W      = 8,
  parameter int NUM_SRC     = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SRC_W       = 2
) (
  input  logic                               clock,
  input  logic                               rst_n,
  input  logic [NUM_SRC-1:0]                 int_req,
  input  logic [NUM_SRC-1:0]                 int_en,
  input  logic [NUM_SRC*ADDR_W-1:0]          int_vec,
  input  logic [ADDR_W-1:0]                  next_pc,
  input  logic                               cur_flag,
  input  logic                               ret,
  output logic                               take,
  output logic [ADDR_W-1:0]                  take_pc,
  output logic [NUM_SRC-1:0]                 int_ack,
  output logic                               restore,
  output logic [ADDR_W-1:0]                  restore_pc,
  output logic                               restore_flag,
  output logic                               in_isr,
  output logic [SRC_W-1:0]                   active_src,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               err_underflow
);

`ifdef INTR_NEST_EN
  localparam int EFF_DEPTH = STACK_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif
  localparam int DQ_W    = $clog2(EFF_DEPTH + 1);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              flag;
    logic [SRC_W-1:0]  src;
  } entry_t;

  entry_t              stack_q [EFF_DEPTH];
  logic [DQ_W-1:0]     depth_q;
  entry_t              top;
  logic [NUM_SRC-1:0]  pending;
  logic                any_pending;
  logic [SRC_W-1:0]    winner;
  logic [ADDR_W-1:0]   win_vec;

  // Entry i holds nesting level i+1, so the top sits at index depth_q-1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    top = '0;
    for (int i = 0; i < EFF_DEPTH; i++) begin
      if (depth_q == DQ_W'(i + 1)) top = stack_q[i];
    end
  end

  // Scan from the lowest priority upwards so the lowest set index wins.
  always_comb begin
    pending     = int_req & int_en;
    any_pending = |pending;
    winner      = '0;
    win_vec     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner  = SRC_W'(i);
        win_vec = int_vec[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ret has priority over entry, so push and pop never coincide; take is held off in reset.
  assign take = rst_n && any_pending && !ret && (depth_q < DQ_W'(EFF_DEPTH)) &&
                ((depth_q == '0) || (winner < top.src));
  assign take_pc      = win_vec;
  assign int_ack      = take ? (NUM_SRC'(1) << winner) : '0;
  assign restore      = ret && (depth_q != '0);
  assign restore_pc   = top.pc;
  assign restore_flag = top.flag;
  assign active_src   = top.src;
  assign in_isr       = (depth_q != '0);
  assign depth        = DEPTH_W'(depth_q);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      depth_q       <= '0;
      err_underflow <= 1'b0;
      // NOTE: the stack is a small flop array, cleared so active_src and restore data read 0 when idle.
      for (int i = 0; i < EFF_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every state update based on pre-edge values.
      if (restore) begin
        depth_q <= depth_q - DQ_W'(1);
      end else if (take) begin
        for (int i = 0; i < EFF_DEPTH; i++) begin
          if (depth_q == DQ_W'(i)) stack_q[i] <= '{pc: next_pc, flag: cur_flag, src: winner};
        end
        depth_q <= depth_q + DQ_W'(1);
      end
      if (ret && (depth_q == '0)) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_intr_nest_unit.sv
// Bench for intr_nest_unit: directed scenarios plus randomized traffic against a queue-based model.
// Follows INTR_NEST_EN the same way the design does.
module tb_intr_nest_unit;
  localparam int ADDR_W = 8, NUM_SRC = 4, STACK_DEPTH = 2, SRC_W = 2, DEPTH_W = 2;
`ifdef INTR_NEST_EN
  localparam bit NEST = 1'b1;
  localparam int EFF  = STACK_DEPTH;
`else
  localparam bit NEST = 1'b0;
  localparam int EFF  = 1;
`endif

  logic clock = 1'b0, rst_n = 1'b0;
  logic [NUM_SRC-1:0] int_req = '0, int_en = '0;
  logic [NUM_SRC*ADDR_W-1:0] int_vec = '0;
  logic [ADDR_W-1:0] next_pc = '0;
  logic cur_flag = 1'b0, ret = 1'b0;
  logic take, restore, restore_flag, in_isr, err_underflow;
  logic [ADDR_W-1:0] take_pc, restore_pc;
  logic [NUM_SRC-1:0] int_ack;
  logic [SRC_W-1:0] active_src;
  logic [DEPTH_W-1:0] depth;

  intr_nest_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .STACK_DEPTH(STACK_DEPTH), .SRC_W(SRC_W)) dut (
    .clock(clock), .rst_n(rst_n), .int_req(int_req), .int_en(int_en), .int_vec(int_vec),
    .next_pc(next_pc), .cur_flag(cur_flag), .ret(ret), .take(take), .take_pc(take_pc),
    .int_ack(int_ack), .restore(restore), .restore_pc(restore_pc), .restore_flag(restore_flag),
    .in_isr(in_isr), .active_src(active_src), .depth(depth), .err_underflow(err_underflow));

  always #5 clock = ~clock;

  typedef struct { logic [ADDR_W-1:0] pc; logic flag; int src; } ent_t;
  ent_t stk[$];
  bit   m_err;
  int   n_checks = 0, n_fail = 0;

  bit               e_take, e_restore, e_flag;
  int               e_win, e_active;
  logic [7:0]       e_take_pc, e_restore_pc;
  logic [3:0]       e_ack;

  function automatic void predict();
    logic [NUM_SRC-1:0] p;
    p = int_req & int_en;
    e_win = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (p[i]) e_win = i;
    e_active = (stk.size() > 0) ? stk[$].src : 0;
    e_take = rst_n && (p != 0) && !ret && (stk.size() < EFF) &&
             (stk.size() == 0 || e_win < e_active);
    e_take_pc = int_vec[e_win*ADDR_W +: ADDR_W];
    e_ack = e_take ? (4'd1 << e_win) : 4'd0;
    e_restore = ret && (stk.size() > 0);
    e_restore_pc = (stk.size() > 0) ? stk[$].pc : 8'h00;
    e_flag = (stk.size() > 0) ? stk[$].flag : 1'b0;
  endfunction

  task automatic tick();
    ent_t e;
    @(posedge clock);
    predict();
    if (e_restore) void'(stk.pop_back());
    else if (e_take) begin
      e.pc = next_pc; e.flag = cur_flag; e.src = e_win;
      stk.push_back(e);
    end
    if (ret && stk.size() == 0 && !e_restore) m_err = 1'b1;
    #1;
  endtask

  task automatic drain();
    int_req = '0; ret = 1'b1;
    for (int i = 0; i < 16 && stk.size() > 0; i++) tick();
    ret = 1'b0; #1;
    n_checks++;
    if (depth !== '0) begin n_fail++; $display("FAIL drain_depth: got %0d want 0", depth); end
  endtask

  task automatic test_reset();
    int_en = 4'b1111; int_req = 4'b0001; ret = 1'b1; #1;
    n_checks++; if (depth !== '0) begin n_fail++; $display("FAIL rst_depth: got %0d want 0", depth); end
    n_checks++; if (take !== 1'b0) begin n_fail++; $display("FAIL rst_take: got %0b want 0", take); end
    n_checks++; if (restore !== 1'b0) begin n_fail++; $display("FAIL rst_restore: got %0b want 0", restore); end
    n_checks++; if ({in_isr, err_underflow, active_src} !== '0) begin
      n_fail++; $display("FAIL rst_state: got isr=%0b err=%0b src=%0d want 0", in_isr, err_underflow, active_src); end
    int_req = '0; ret = 1'b0; #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int_en = 4'b0100; int_req = 4'b0100; int_vec[2*ADDR_W +: ADDR_W] = 8'h40;
    next_pc = 8'h13; cur_flag = 1'b1; #1;
    n_checks++; if (take !== 1'b1) begin n_fail++; $display("FAIL single_take: got %0b want 1", take); end
    n_checks++; if (take_pc !== 8'h40) begin n_fail++; $display("FAIL single_take_pc: got %h want 40", take_pc); end
    n_checks++; if (int_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", int_ack); end
    tick(); int_req = '0; next_pc = 8'h99; cur_flag = 1'b0; #1;
    n_checks++; if (depth !== 2'd1 || active_src !== 2'd2 || in_isr !== 1'b1) begin
      n_fail++; $display("FAIL single_entered: got depth=%0d src=%0d isr=%0b want 1 2 1", depth, active_src, in_isr); end
    ret = 1'b1; #1;
    n_checks++; if ({restore, restore_pc, restore_flag} !== {1'b1, 8'h13, 1'b1}) begin
      n_fail++; $display("FAIL single_restore: got %0b %h %0b want 1 13 1", restore, restore_pc, restore_flag); end
    tick(); ret = 1'b0; #1;
    n_checks++; if (depth !== '0) begin n_fail++; $display("FAIL single_exit_depth: got %0d want 0", depth); end
  endtask

  task automatic test_preempt();
    int_en = 4'b1111; int_req = 4'b0100; tick();
    int_req = 4'b0001; int_vec[0 +: ADDR_W] = 8'h20; #1;
    n_checks++; if (take !== NEST) begin n_fail++; $display("FAIL preempt_take: got %0b want %0b", take, NEST); end
    n_checks++; if (take_pc !== 8'h20) begin n_fail++; $display("FAIL preempt_pc: got %h want 20", take_pc); end
    tick(); #1;
    n_checks++; if (depth !== (NEST ? 2'd2 : 2'd1) || active_src !== (NEST ? 2'd0 : 2'd2)) begin
      n_fail++; $display("FAIL preempt_state: got depth=%0d src=%0d", depth, active_src); end
    int_req = 4'b1000; #1;
    n_checks++; if (take !== 1'b0) begin n_fail++; $display("FAIL preempt_lower: got %0b want 0", take); end
    drain();
  endtask

  task automatic test_full_and_collision();
    int_en = 4'b1111; int_req = 4'b1000; tick();
    int_req = 4'b0100; tick();
    int_req = 4'b0001; #1;
    n_checks++; if (take !== 1'b0) begin n_fail++; $display("FAIL full_take: got %0b want 0", take); end
    ret = 1'b1; #1;
    n_checks++; if (restore !== 1'b1 || take !== 1'b0) begin
      n_fail++; $display("FAIL full_ret: got restore=%0b take=%0b want 1 0", restore, take); end
    tick(); ret = 1'b0; #1;
    n_checks++; if (take !== 1'b1) begin n_fail++; $display("FAIL full_tailchain: got %0b want 1", take); end
    tick(); drain();
    // Collision: ret and a higher-priority request in the same cycle.
    int_req = 4'b0100; tick();
    int_req = 4'b0010; ret = 1'b1; next_pc = 8'h55; #1;
    n_checks++; if (restore !== 1'b1 || take !== 1'b0) begin
      n_fail++; $display("FAIL coll_ret: got restore=%0b take=%0b want 1 0", restore, take); end
    tick(); ret = 1'b0; next_pc = 8'h77; cur_flag = 1'b0; #1;
    n_checks++; if (take !== 1'b1 || int_ack !== 4'b0010) begin
      n_fail++; $display("FAIL coll_take: got take=%0b ack=%b want 1 0010", take, int_ack); end
    tick(); int_req = '0; ret = 1'b1; #1;
    n_checks++; if ({active_src, restore_pc, restore_flag} !== {2'd1, 8'h77, 1'b0}) begin
      n_fail++; $display("FAIL coll_entry: got src=%0d pc=%h flag=%0b want 1 77 0", active_src, restore_pc, restore_flag); end
    tick(); drain();
  endtask

  task automatic test_underflow();
    int_req = '0; ret = 1'b1; #1;
    n_checks++; if (restore !== 1'b0) begin n_fail++; $display("FAIL uf_restore: got %0b want 0", restore); end
    tick(); ret = 1'b0; tick(); tick(); #1;
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %0b want 1", err_underflow); end
    int_en = 4'b1111; int_req = 4'b0100; tick();
    int_req = 4'b0001; #1;
    n_checks++; if (take !== NEST) begin n_fail++; $display("FAIL uf_second_req: got %0b want %0b", take, NEST); end
    drain();
  endtask

  task automatic test_async_reset();
    int_en = 4'b1111; int_req = 4'b1000; tick();
    int_req = 4'b0100; tick();
    int_req = 4'b0001; #2 rst_n = 1'b0; #1;
    stk.delete(); m_err = 1'b0;
    n_checks++; if ({depth, in_isr, take, err_underflow} !== '0) begin
      n_fail++; $display("FAIL async_rst: got depth=%0d isr=%0b take=%0b err=%0b want 0", depth, in_isr, take, err_underflow); end
    int_req = '0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int_en   = 4'($urandom_range(0, 15)) | 4'b0001;
      int_req  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      ret      = ($urandom_range(0, 4) == 0);
      next_pc  = 8'($urandom);
      cur_flag = 1'($urandom);
      if (c % 16 == 0) int_vec = 32'($urandom);
      #1; predict();
      n_checks++;
      if ({take, int_ack, restore} !== {e_take, e_ack, e_restore}) begin
        n_fail++; $display("FAIL rnd_ctl c=%0d: got take=%0b ack=%b rst=%0b want %0b %b %0b",
                           c, take, int_ack, restore, e_take, e_ack, e_restore); end
      n_checks++;
      if (depth !== DEPTH_W'(stk.size()) || int'(active_src) != e_active || in_isr !== (stk.size() > 0) ||
          err_underflow !== m_err) begin
        n_fail++; $display("FAIL rnd_state c=%0d: got depth=%0d src=%0d isr=%0b err=%0b want %0d %0d %0b",
                           c, depth, active_src, in_isr, err_underflow, stk.size(), e_active, m_err); end
      if (e_take) begin
        n_checks++;
        if (take_pc !== e_take_pc) begin n_fail++; $display("FAIL rnd_take_pc c=%0d: got %h want %h", c, take_pc, e_take_pc); end
      end
      if (e_restore) begin
        n_checks++;
        if ({restore_pc, restore_flag} !== {e_restore_pc, e_flag}) begin
          n_fail++; $display("FAIL rnd_restore c=%0d: got %h %0b want %h %0b", c, restore_pc, restore_flag, e_restore_pc, e_flag); end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_err = 1'b0;
    test_reset();
    test_single();
    test_preempt();
    test_full_and_collision();
    test_underflow();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
